// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, accumulator state type and width helper
package adder_pkg;

  localparam int SUM_W = 5;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Widest frame total is max_cnt * (2^sum_w - 1), which always fits here
  function automatic int acc_w(input int sum_w, input int max_cnt);
    return sum_w + $clog2(max_cnt);
  endfunction

endpackage

// File: rtl/acc_out_reg.sv
// acc_out_reg: one-entry output holding register with valid/ready handshake
module acc_out_reg #(
  parameter int TOTAL_W = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [TOTAL_W-1:0] load_total,
  input  logic [COUNT_W-1:0] load_count,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [TOTAL_W-1:0] out_total,
  output logic [COUNT_W-1:0] out_count
);

  // Capture a closed frame and hold it until downstream takes it; clear drops it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_total <= '0;
      out_count <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_total <= '0;
      out_count <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_total <= load_total;
      out_count <= load_count;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates adder sums into per-frame totals over valid/ready
module sum_accumulator #(
  parameter int SUM_W   = adder_pkg::SUM_W,
  parameter int MAX_CNT = 8,
  parameter int CNT_W   = $clog2(MAX_CNT) + 1,
  parameter int ACC_W   = adder_pkg::acc_w(SUM_W, MAX_CNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  import adder_pkg::*;

  if (ACC_W < SUM_W + $clog2(MAX_CNT) || MAX_CNT < 2 || (MAX_CNT & (MAX_CNT - 1)) != 0) begin : g_bad_params
    $error("sum_accumulator: ACC_W too narrow or MAX_CNT not a power of two >= 2");
  end

  acc_state_t       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             accept, closing;

  // in_ready comes straight off the state flop, so it carries no input path
  assign in_ready = state == ACCUM;
  assign accept   = in_valid && in_ready && !clr;
  assign acc_sum  = acc + ACC_W'(in_sum);
  assign cnt_inc  = cnt + CNT_W'(1);
  assign closing  = accept && (cnt_inc == CNT_W'(MAX_CNT) || in_last);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next state: abort wins, a closing accept enters HOLD, the output handshake leaves it
  always_comb begin
    state_nxt = state;
    state_nxt = clr                        ? ACCUM :
                closing                    ? HOLD  :
                (state == HOLD && out_ready) ? ACCUM : state;
  end

  // Running total and sample count, restarted at every frame boundary or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr || closing) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_sum;
      cnt <= cnt_inc;
    end
  end

  acc_out_reg #(
    .TOTAL_W(ACC_W),
    .COUNT_W(CNT_W)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (closing),
    .load_total(acc_sum),
    .load_count(cnt_inc),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_total (out_total),
    .out_count (out_count)
  );

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed stimulus checked against a frame-level model every cycle
module tb_sum_accumulator;

  localparam int MAX_CNT = 8;

  logic       clk = 0, rst_n = 0, clr = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [4:0] in_sum = 0;
  logic       in_ready, out_valid;
  logic [7:0] out_total;
  logic [3:0] out_count;

  int checks = 0, failures = 0;
  int frames = 0, last_total = 0, last_count = 0, lo_cnt = 0, frames0 = 0;

  bit m_hold = 0;
  int q[$];
  int m_total = 0, m_count = 0;

  sum_accumulator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_sum   (in_sum),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_total(out_total),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a queue of accepted samples, closed by count or last
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_hold = 0;
      q.delete();
    end else if (clr) begin
      m_hold = 0;
      q.delete();
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      q.push_back(int'(in_sum));
      if (q.size() == MAX_CNT || in_last) begin
        m_total = 0;
        foreach (q[i]) m_total += q[i];
        m_count = q.size();
        q.delete();
        m_hold = 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus capture of delivered frames
  initial forever begin
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(!m_hold));
    chk("out_valid", int'(out_valid), int'(m_hold));
    if (m_hold) begin
      chk("out_total", int'(out_total), m_total);
      chk("out_count", int'(out_count), m_count);
    end
    if (!in_ready) lo_cnt++;
    if (out_valid && out_ready) begin
      last_total = int'(out_total);
      last_count = int'(out_count);
      frames++;
    end
  end

  task automatic send(input int s, input bit l);
    in_sum   = 5'(s);
    in_last  = l;
    in_valid = 1;
    for (int k = 0; k < 50 && !in_ready; k++) begin
      @(posedge clk);
      #1;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic wait_frame();
    for (int k = 0; k < 50 && frames == frames0; k++) @(posedge clk);
    if (frames == frames0) chk("frame_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_total"}, int'(out_total), 0);
    chk({tag, "_out_count"}, int'(out_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    #2;
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1;

    lo_cnt  = 0;
    frames0 = frames;
    for (int i = 0; i < 8; i++) send(16, 0);
    wait_frame();
    repeat (2) @(posedge clk);
    #1;
    chk("full_total", last_total, 128);
    chk("full_count", last_count, 8);
    chk("model_full_total", m_total, 128);
    chk("in_ready_low_cycles", lo_cnt, 1);

    frames0 = frames;
    send(8, 0);
    send(15, 0);
    send(16, 1);
    wait_frame();
    chk("last_total", last_total, 39);
    chk("last_count", last_count, 3);
    chk("model_last_total", m_total, 39);

    frames0 = frames;
    for (int i = 0; i < 8; i++) send(31, 0);
    wait_frame();
    chk("max_total", last_total, 248);
    chk("max_count", last_count, 8);

    out_ready = 0;
    send(3, 0);
    send(4, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_total", int'(out_total), 7);
      chk("bp_out_count", int'(out_count), 2);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);

    frames0 = frames;
    for (int i = 0; i < 4; i++) send(5, 0);
    clr      = 1;
    in_valid = 1;
    in_sum   = 7;
    @(posedge clk);
    #1;
    clr      = 0;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("clr_no_output", frames, frames0);
    for (int i = 0; i < 8; i++) send(1, 0);
    wait_frame();
    chk("post_clr_total", last_total, 8);
    chk("post_clr_count", last_count, 8);

    for (int i = 0; i < 3; i++) send(9, 0);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk_reset("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1;

    out_ready = 0;
    send(20, 0);
    send(21, 1);
    @(posedge clk);
    #4;
    rst_n = 0;
    #1;
    chk_reset("rst_hold");
    @(posedge clk);
    #1;
    rst_n     = 1;
    out_ready = 1;

    frames0 = frames;
    for (int i = 0; i < 8; i++) send(2, 0);
    wait_frame();
    chk("post_rst_total", last_total, 16);
    chk("post_rst_count", last_count, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
